x_phaser_in_calib_mc: RTL and testbench

- Multi-lane fine-delay tap controller with an automatic DQS edge search, modelling the calibration half of a phaser-in for LANES byte lanes.
- Holds one TAP_WIDTH-bit tap per lane.
- Sources of tap changes: per-lane manual fine inc/dec, counter load/readback through a lane select, and a sweep state machine that finds each lane's DQS rising edge.
- Sits between the memory-controller calibration logic and the per-lane delay lines, all in the SYSCLK domain.

---
 rtl/x_phaser_in_calib_mc_if.sv | 35 +++
 rtl/x_phaser_in_calib_mc.sv | 193 +++++++++++++++++++
 tb/tb_x_phaser_in_calib_mc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/x_phaser_in_calib_mc_if.sv
// Calibration-side bundle of the phaser-in tap controller: manual adjust,
// load/readback, edge-search control and the per-lane tap/status results.
interface x_phaser_in_calib_mc_if #(
  parameter int LANES     = 4,
  parameter int TAP_WIDTH = 6
);
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]           FINEENABLE;
  logic [LANES-1:0]           FINEINC;
  logic [SEL_W-1:0]           LANESEL;
  logic                       COUNTERLOADEN;
  logic [TAP_WIDTH-1:0]       COUNTERLOADVAL;
  logic                       COUNTERREADEN;
  logic                       RSTDQSFIND;
  logic [LANES-1:0]           SAMPLE;
  logic [LANES*TAP_WIDTH-1:0] TAP;
  logic [TAP_WIDTH-1:0]       COUNTERREADVAL;
  logic [LANES-1:0]           FINEOVERFLOW;
  logic                       DQSFOUND;
  logic                       DQSOUTOFRANGE;
  logic                       BUSY;

  modport master (
    output FINEENABLE, FINEINC, LANESEL, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, RSTDQSFIND, SAMPLE,
    input  TAP, COUNTERREADVAL, FINEOVERFLOW, DQSFOUND, DQSOUTOFRANGE, BUSY
  );

  modport slave (
    input  FINEENABLE, FINEINC, LANESEL, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, RSTDQSFIND, SAMPLE,
    output TAP, COUNTERREADVAL, FINEOVERFLOW, DQSFOUND, DQSOUTOFRANGE, BUSY
  );
endinterface

// File: rtl/x_phaser_in_calib_mc.sv
// Multi-lane fine-delay tap controller with DQS rising-edge search.
// Define X_PHASER_IN_CALIB_CENTER_EN to centre each tap between rise and fall.
//
// state  | meaning
// IDLE   | manual adjust / load allowed, waiting for RSTDQSFIND
// SETTLE | delay line settling after a tap step (down-counter)
// SAMPLE | one-cycle edge detect on SAMPLE, decide DONE/FAIL/STEP
// STEP   | advance every still-sweeping lane by one tap
// DONE   | search succeeded, final taps applied
// FAIL   | search ran out of taps
module x_phaser_in_calib_mc #(
  parameter int LANES         = 4,
  parameter int TAP_WIDTH     = 6,
  parameter int SETTLE_CYCLES = 8,
  parameter int FINE_DELAY    = 0
) (
  input logic                   SYSCLK,
  input logic                   RST,
  x_phaser_in_calib_mc_if.slave bus
);
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_WIDTH-1:0] TAP_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_STEP, ST_DONE, ST_FAIL
  } state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [TAP_WIDTH-1:0]            sweep;
  logic [LANES-1:0][TAP_WIDTH-1:0] tap_q;
  logic [LANES-1:0][TAP_WIDTH-1:0] rise_q;
  logic [LANES-1:0]                prev_q;
  logic [LANES-1:0]                rose_q;
  logic [TAP_WIDTH-1:0]            rd_q;
  logic [LANES-1:0]                ovf_q;
  logic                            found_q;
  logic                            oor_q;
  logic                            busy_q;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
  logic [LANES-1:0]                done_q;
  logic [LANES-1:0][TAP_WIDTH-1:0] fall_q;
  logic [LANES-1:0]                hit_fall;
  logic [LANES-1:0][TAP_WIDTH-1:0] fall_eff;
  logic [TAP_WIDTH:0]              sum;
`endif

  logic                            sel_ok;
  logic [LANES-1:0]                hit_rise;
  logic [LANES-1:0]                active;
  logic [LANES-1:0]                complete_nx;
  logic [LANES-1:0][TAP_WIDTH-1:0] rise_eff;
  logic [LANES-1:0][TAP_WIDTH-1:0] fin_tap;

  assign sel_ok             = int'(bus.LANESEL) < LANES;
  assign bus.TAP            = tap_q;
  assign bus.COUNTERREADVAL = rd_q;
  assign bus.FINEOVERFLOW   = ovf_q;
  assign bus.DQSFOUND       = found_q;
  assign bus.DQSOUTOFRANGE  = oor_q;
  assign bus.BUSY           = busy_q;

  always_comb begin
    hit_rise    = '0;
    active      = '0;
    complete_nx = '0;
    rise_eff    = '0;
    fin_tap     = '0;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
    hit_fall    = '0;
    fall_eff    = '0;
    sum         = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      // prev starts at 1, so a lane already high must go low before a rise counts
      hit_rise[i] = !rose_q[i] && bus.SAMPLE[i] && !prev_q[i];
      rise_eff[i] = hit_rise[i] ? sweep : rise_q[i];
`ifdef X_PHASER_IN_CALIB_CENTER_EN
      hit_fall[i]    = rose_q[i] && !done_q[i] && !bus.SAMPLE[i] && prev_q[i];
      active[i]      = !done_q[i];
      complete_nx[i] = done_q[i] || hit_fall[i] ||
                       ((rose_q[i] || hit_rise[i]) && (sweep == TAP_MAX));
      fall_eff[i]    = done_q[i] ? fall_q[i] : (hit_fall[i] ? sweep : TAP_MAX);
      sum            = {1'b0, rise_eff[i]} + {1'b0, fall_eff[i]};
      fin_tap[i]     = sum[TAP_WIDTH:1];
`else
      active[i]      = !rose_q[i];
      complete_nx[i] = rose_q[i] || hit_rise[i];
      fin_tap[i]     = rise_eff[i];
`endif
    end
  end

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sweep   <= '0;
      tap_q   <= {LANES{TAP_WIDTH'(FINE_DELAY)}};
      rise_q  <= '0;
      prev_q  <= '1;
      rose_q  <= '0;
      rd_q    <= '0;
      ovf_q   <= '0;
      found_q <= 1'b0;
      oor_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
      done_q  <= '0;
      fall_q  <= '0;
`endif
    end else begin
      ovf_q <= '0;
      if (bus.COUNTERREADEN)
        rd_q <= sel_ok ? tap_q[bus.LANESEL] : '0;

      if (bus.RSTDQSFIND) begin
        state   <= ST_SETTLE;
        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
        sweep   <= '0;
        tap_q   <= '0;
        rose_q  <= '0;
        prev_q  <= '1;
        found_q <= 1'b0;
        oor_q   <= 1'b0;
        busy_q  <= 1'b1;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
        done_q  <= '0;
`endif
      end else begin
        if (!busy_q) begin
          for (int i = 0; i < LANES; i++) begin
            // a load to the same lane overrides the fine step and its wrap pulse
            if (bus.COUNTERLOADEN && sel_ok && (bus.LANESEL == SEL_W'(i))) begin
              tap_q[i] <= bus.COUNTERLOADVAL;
            end else if (bus.FINEENABLE[i]) begin
              if (bus.FINEINC[i]) begin
                tap_q[i] <= tap_q[i] + 1'b1;
                ovf_q[i] <= (tap_q[i] == TAP_MAX);
              end else begin
                tap_q[i] <= tap_q[i] - 1'b1;
                ovf_q[i] <= (tap_q[i] == '0);
              end
            end
          end
        end

        case (state)
          ST_IDLE: ;
          ST_SETTLE: begin
            if (cnt == '0) state <= ST_SAMPLE;
            else           cnt   <= cnt - 1'b1;
          end
          ST_SAMPLE: begin
            prev_q <= bus.SAMPLE;
            rose_q <= rose_q | hit_rise;
            rise_q <= rise_eff;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
            done_q <= complete_nx;
            for (int i = 0; i < LANES; i++)
              if (hit_fall[i]) fall_q[i] <= sweep;
`endif
            if (&complete_nx) begin
              state   <= ST_DONE;
              tap_q   <= fin_tap;
              found_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (sweep == TAP_MAX) begin
              state  <= ST_FAIL;
              for (int i = 0; i < LANES; i++)
                tap_q[i] <= (rose_q[i] || hit_rise[i]) ? rise_eff[i] : TAP_MAX;
              oor_q  <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state <= ST_STEP;
            end
          end
          ST_STEP: begin
            sweep <= sweep + 1'b1;
            for (int i = 0; i < LANES; i++)
              if (active[i]) tap_q[i] <= sweep + 1'b1;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
          end
          ST_DONE: state <= ST_IDLE;
          ST_FAIL: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_x_phaser_in_calib_mc.sv
// Bench for x_phaser_in_calib_mc: table-driven manual adjust/load/readback
// vectors plus edge-search, restart and async-reset sequences.
module tb_x_phaser_in_calib_mc;
  localparam int LANES = 4;
  localparam int TW    = 6;
  localparam int SC    = 2;
  localparam int FD    = 5;

  logic SYSCLK = 1'b0;
  logic RST;

  x_phaser_in_calib_mc_if #(.LANES(LANES), .TAP_WIDTH(TW)) bus ();

  x_phaser_in_calib_mc #(
    .LANES(LANES), .TAP_WIDTH(TW), .SETTLE_CYCLES(SC), .FINE_DELAY(FD)
  ) dut (
    .SYSCLK(SYSCLK),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;

  // delay-line model: lane i reads high while its tap is in [rise, fall)
  int               rise_tb [LANES];
  int               fall_tb [LANES];
  logic [LANES-1:0] stuck;

  always_comb begin
    bus.SAMPLE = '0;
    for (int i = 0; i < LANES; i++)
      bus.SAMPLE[i] = stuck[i] ||
                      ((int'(bus.TAP[i*TW +: TW]) >= rise_tb[i]) &&
                       (int'(bus.TAP[i*TW +: TW]) <  fall_tb[i]));
  end

  typedef struct {
    logic [3:0]  fen;
    logic [3:0]  finc;
    logic [1:0]  sel;
    logic        ld;
    logic [5:0]  ldv;
    logic        rd;
    logic [23:0] exp_tap;
    logic [3:0]  exp_ovf;
    logic [5:0]  exp_rd;
  } vec_t;

  typedef struct {
    logic [23:0] tap;
    logic        found;
    logic        oor;
    int          cyc;
  } sexp_t;

  vec_t  sb [$];
  sexp_t sq [$];

  function automatic logic [23:0] taps4(int a, int b, int c, int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic vec_t mk(logic [3:0] fen, logic [3:0] finc, logic [1:0] sel,
                              logic ld, logic [5:0] ldv, logic rd,
                              logic [23:0] et, logic [3:0] eo, logic [5:0] er);
    vec_t v;
    v.fen = fen; v.finc = finc; v.sel = sel; v.ld = ld; v.ldv = ldv; v.rd = rd;
    v.exp_tap = et; v.exp_ovf = eo; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.FINEENABLE     = '0;
    bus.FINEINC        = '0;
    bus.LANESEL        = '0;
    bus.COUNTERLOADEN  = 1'b0;
    bus.COUNTERLOADVAL = '0;
    bus.COUNTERREADEN  = 1'b0;
    bus.RSTDQSFIND     = 1'b0;
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic start_search(input sexp_t e);
    sq.push_back(e);
    bus.RSTDQSFIND = 1'b1;
    tick();
    bus.RSTDQSFIND = 1'b0;
    chk("start_busy",  32'(bus.BUSY), 32'd1);
    chk("start_taps",  32'(bus.TAP), 32'd0);
    chk("start_status", 32'({bus.DQSFOUND, bus.DQSOUTOFRANGE}), 32'd0);
  endtask

  task automatic finish_search(input string nm, input int cyc0);
    int    cyc;
    sexp_t e;
    cyc = cyc0;
    while (!(bus.DQSFOUND || bus.DQSOUTOFRANGE) && cyc < 3000) begin
      tick();
      cyc++;
    end
    e = sq.pop_front();
    chk({nm, "_cycles"}, 32'(cyc), 32'(e.cyc));
    chk({nm, "_taps"},   32'(bus.TAP), 32'(e.tap));
    chk({nm, "_found"},  32'(bus.DQSFOUND), 32'(e.found));
    chk({nm, "_oor"},    32'(bus.DQSOUTOFRANGE), 32'(e.oor));
    chk({nm, "_busy"},   32'(bus.BUSY), 32'd0);
  endtask

  vec_t  vecs [12];
  sexp_t e_ok, e_fail;
  int    n;

  initial begin
    vecs[0]  = mk(4'b0000, 4'b0000, 2'd2, 1'b1, 6'd63, 1'b0, taps4(5, 5, 63, 5), 4'b0000, 6'd0);
    vecs[1]  = mk(4'b0100, 4'b0100, 2'd0, 1'b0, 6'd0,  1'b0, taps4(5, 5, 0, 5),  4'b0100, 6'd0);
    vecs[2]  = mk(4'b0000, 4'b0000, 2'd0, 1'b0, 6'd0,  1'b0, taps4(5, 5, 0, 5),  4'b0000, 6'd0);
    vecs[3]  = mk(4'b0100, 4'b0000, 2'd0, 1'b0, 6'd0,  1'b0, taps4(5, 5, 63, 5), 4'b0100, 6'd0);
    vecs[4]  = mk(4'b0000, 4'b0000, 2'd0, 1'b0, 6'd0,  1'b0, taps4(5, 5, 63, 5), 4'b0000, 6'd0);
    vecs[5]  = mk(4'b0010, 4'b0010, 2'd1, 1'b1, 6'd17, 1'b0, taps4(5, 17, 63, 5), 4'b0000, 6'd0);
    vecs[6]  = mk(4'b0000, 4'b0000, 2'd1, 1'b0, 6'd0,  1'b1, taps4(5, 17, 63, 5), 4'b0000, 6'd17);
    vecs[7]  = mk(4'b1001, 4'b1000, 2'd2, 1'b0, 6'd0,  1'b1, taps4(4, 17, 63, 6), 4'b0000, 6'd63);
    vecs[8]  = mk(4'b1000, 4'b1000, 2'd3, 1'b0, 6'd0,  1'b1, taps4(4, 17, 63, 7), 4'b0000, 6'd6);
    vecs[9]  = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 6'd5,  1'b0, taps4(4, 17, 5, 7),  4'b0000, 6'd6);
    vecs[10] = mk(4'b1111, 4'b1111, 2'd0, 1'b0, 6'd0,  1'b1, taps4(5, 18, 6, 8),  4'b0000, 6'd4);
    vecs[11] = mk(4'b0001, 4'b0000, 2'd3, 1'b1, 6'd0,  1'b0, taps4(4, 18, 6, 0),  4'b0000, 6'd4);

    rise_tb = '{10, 20, 30, 40};
    fall_tb = '{14, 24, 34, 63};
    stuck   = '0;
`ifdef X_PHASER_IN_CALIB_CENTER_EN
    e_ok = '{tap: taps4(12, 22, 32, 51), found: 1'b1, oor: 1'b0, cyc: 256};
`else
    e_ok = '{tap: taps4(10, 20, 30, 40), found: 1'b1, oor: 1'b0, cyc: 164};
`endif
    e_fail = '{tap: taps4(10, 20, 30, 63), found: 1'b0, oor: 1'b1, cyc: 256};

    clear_inputs();
    RST = 1'b1;
    repeat (3) tick();
    chk("reset_taps",   32'(bus.TAP), 32'(taps4(FD, FD, FD, FD)));
    chk("reset_rdval",  32'(bus.COUNTERREADVAL), 32'd0);
    chk("reset_status", 32'({bus.FINEOVERFLOW, bus.DQSFOUND, bus.DQSOUTOFRANGE, bus.BUSY}), 32'd0);
    RST = 1'b0;
    tick();

    for (int k = 0; k < 12; k++) begin
      vec_t v;
      bus.FINEENABLE     = vecs[k].fen;
      bus.FINEINC        = vecs[k].finc;
      bus.LANESEL        = vecs[k].sel;
      bus.COUNTERLOADEN  = vecs[k].ld;
      bus.COUNTERLOADVAL = vecs[k].ldv;
      bus.COUNTERREADEN  = vecs[k].rd;
      sb.push_back(vecs[k]);
      tick();
      clear_inputs();
      v = sb.pop_front();
      chk($sformatf("vec%0d_tap", k), 32'(bus.TAP), 32'(v.exp_tap));
      chk($sformatf("vec%0d_ovf", k), 32'(bus.FINEOVERFLOW), 32'(v.exp_ovf));
      chk($sformatf("vec%0d_rd", k),  32'(bus.COUNTERREADVAL), 32'(v.exp_rd));
    end

    start_search(e_ok);
    finish_search("search_ok", 1);
    tick();

    stuck = 4'b1000;
    start_search(e_fail);
    finish_search("search_fail", 1);
    tick();
    stuck = '0;

    // restart at tap 7, then a blocked fine decrement and a readback while busy
    start_search(e_ok);
    n = 0;
    while (bus.TAP[5:0] != 6'd7 && n < 200) begin
      tick();
      n++;
    end
    chk("restart_reach7", 32'(bus.TAP[5:0]), 32'd7);
    bus.RSTDQSFIND = 1'b1;
    tick();
    bus.RSTDQSFIND = 1'b0;
    chk("restart_taps", 32'(bus.TAP), 32'd0);
    chk("restart_busy", 32'(bus.BUSY), 32'd1);
    chk("restart_status", 32'({bus.DQSFOUND, bus.DQSOUTOFRANGE}), 32'd0);
    bus.FINEENABLE    = 4'b1111;
    bus.FINEINC       = 4'b0000;
    bus.COUNTERREADEN = 1'b1;
    bus.LANESEL       = 2'd3;
    tick();
    clear_inputs();
    chk("busy_fine_taps", 32'(bus.TAP), 32'd0);
    chk("busy_fine_ovf",  32'(bus.FINEOVERFLOW), 32'd0);
    chk("busy_readback",  32'(bus.COUNTERREADVAL), 32'd0);
    finish_search("search_restart", 2);
    tick();

    bus.RSTDQSFIND = 1'b1;
    tick();
    bus.RSTDQSFIND = 1'b0;
    repeat (5) tick();
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_taps", 32'(bus.TAP), 32'(taps4(FD, FD, FD, FD)));
    chk("async_rst_status", 32'({bus.DQSFOUND, bus.DQSOUTOFRANGE, bus.BUSY}), 32'd0);
    #1;
    RST = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
